// File: rtl/myriadrf_rx_fifo_if.sv
// MyriadRF RX front-end: pairs the interleaved A/B sample stream into {A,B} words
// and buffers them in a first-word-fall-through FIFO with drop and slip counters.
module myriadrf_rx_fifo_if #(
  parameter int DW         = 12,
  parameter int DEPTH_LOG2 = 4,
  parameter int SWAP       = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_i,
  input  logic [DW-1:0]         rxd,
  input  logic                  rxiqsel,
  output logic [2*DW-1:0]       m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  ovf_o,
  output logic [CNT_W-1:0]      ovf_cnt_o,
  output logic                  sync_err_o,
  output logic [CNT_W-1:0]      sync_cnt_o
);

  localparam int                 DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ZERO_LVL = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic               WAIT_A   = 1'b0;
  localparam logic               HAVE_A   = 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [DW-1:0]         rxd_r;
  logic                  iq_r;
  logic                  en_r;
  logic                  state_r;
  logic [DW-1:0]         a_hold_r;
  logic [2*DW-1:0]       mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   mcnt_r;

  logic                  state_nxt_s;
  logic [DW-1:0]         a_nxt_s;
  logic                  push_s;
  logic                  slip_s;
  logic [2*DW-1:0]       word_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  push_ok_s;
  logic                  drop_s;
  logic                  load_s;

  // Input capture stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_r <= {DW{1'b0}};
      iq_r  <= 1'b0;
      en_r  <= 1'b0;
    end else begin
      rxd_r <= rxd;
      iq_r  <= rxiqsel;
      en_r  <= en;
    end
  end

  // Pairing decision: an A waits for its B; a repeated phase is a slip
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_hold_r;
    push_s      = 1'b0;
    slip_s      = 1'b0;
    if (!en_r) begin
      state_nxt_s = WAIT_A;
    end else begin
      case (state_r)
        WAIT_A: begin
          if (!iq_r) begin
            a_nxt_s     = rxd_r;
            state_nxt_s = HAVE_A;
          end else begin
            slip_s = 1'b1;
          end
        end
        HAVE_A: begin
          if (iq_r) begin
            push_s      = 1'b1;
            state_nxt_s = WAIT_A;
          end else begin
            slip_s  = 1'b1;
            a_nxt_s = rxd_r;
          end
        end
        default: state_nxt_s = WAIT_A;
      endcase
    end
  end

  assign word_s    = (SWAP != 0) ? {rxd_r, a_hold_r} : {a_hold_r, rxd_r};
  assign pop_s     = m_valid_o & m_ready_i;
  assign full_s    = (level_o == FULL_LVL);
  assign push_ok_s = push_s & (~full_s | pop_s);
  assign drop_s    = push_s & full_s & ~pop_s;
  // Output register refills whenever it is free or being consumed and RAM has data
  assign load_s    = (~m_valid_o | pop_s) & (mcnt_r != ZERO_LVL);

  // Pairing state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= WAIT_A;
      a_hold_r <= {DW{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      a_hold_r <= a_nxt_s;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  // FIFO pointers, occupancy and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r  <= {DEPTH_LOG2{1'b0}};
      mcnt_r    <= ZERO_LVL;
      level_o   <= ZERO_LVL;
      m_valid_o <= 1'b0;
      m_data_o  <= {(2*DW){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
      end
      if (load_s) begin
        m_data_o <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
      end
      m_valid_o <= load_s | (m_valid_o & ~pop_s);
      case ({push_ok_s, load_s})
        2'b10:   mcnt_r <= mcnt_r + (DEPTH_LOG2+1)'(1);
        2'b01:   mcnt_r <= mcnt_r - (DEPTH_LOG2+1)'(1);
        default: mcnt_r <= mcnt_r;
      endcase
      case ({push_ok_s, pop_s})
        2'b10:   level_o <= level_o + (DEPTH_LOG2+1)'(1);
        2'b01:   level_o <= level_o - (DEPTH_LOG2+1)'(1);
        default: level_o <= level_o;
      endcase
    end
  end

  // Sticky flags and saturating counters; clear beats a coincident event
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      ovf_o      <= 1'b0;
      ovf_cnt_o  <= {CNT_W{1'b0}};
      sync_err_o <= 1'b0;
      sync_cnt_o <= {CNT_W{1'b0}};
    end else begin
      if (drop_s) begin
        ovf_o     <= 1'b1;
        ovf_cnt_o <= sat_inc(ovf_cnt_o);
      end
      if (slip_s) begin
        sync_err_o <= 1'b1;
        sync_cnt_o <= sat_inc(sync_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_myriadrf_rx_fifo_if.sv
// Bench for myriadrf_rx_fifo_if: two instances (SWAP=0/CNT_W=16, SWAP=1/CNT_W=3)
// compared each cycle against a queue-based model, plus directed literal checks.
module tb_myriadrf_rx_fifo_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr_i = 1'b0;
  logic [11:0] rxd = 12'h000;
  logic        rxiqsel = 1'b0;
  logic        m_ready_i = 1'b0;

  logic [23:0] d0, d1;
  logic        v0, v1;
  logic [2:0]  l0, l1;
  logic        ovf0, ovf1, se0, se1;
  logic [15:0] oc0, sc0;
  logic [2:0]  oc1, sc1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  myriadrf_rx_fifo_if #(.DW(12), .DEPTH_LOG2(2), .SWAP(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .en(en), .clr_i(clr_i), .rxd(rxd), .rxiqsel(rxiqsel),
    .m_data_o(d0), .m_valid_o(v0), .m_ready_i(m_ready_i), .level_o(l0),
    .ovf_o(ovf0), .ovf_cnt_o(oc0), .sync_err_o(se0), .sync_cnt_o(sc0));

  myriadrf_rx_fifo_if #(.DW(12), .DEPTH_LOG2(2), .SWAP(1), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr_i(clr_i), .rxd(rxd), .rxiqsel(rxiqsel),
    .m_data_o(d1), .m_valid_o(v1), .m_ready_i(m_ready_i), .level_o(l1),
    .ovf_o(ovf1), .ovf_cnt_o(oc1), .sync_err_o(se1), .sync_cnt_o(sc1));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          t = 0;
  logic [11:0] mq_rxd = 12'h000;
  logic        mq_iq = 1'b0;
  logic        mq_en = 1'b0;
  bit          have_a = 1'b0;
  logic [11:0] a_val = 12'h000;
  logic [23:0] q[$];
  int          qt[$];
  bit          mv = 1'b0;
  bit          movf = 1'b0;
  bit          msync = 1'b0;
  int          mo16 = 0, ms16 = 0, mo3 = 0, ms3 = 0;

  always @(posedge clk) begin : model
    bit          pop, push, slip, full, drop;
    logic [23:0] w;
    t++;
    if (rst) begin
      q.delete(); qt.delete();
      have_a = 1'b0; a_val = 12'h000;
      mq_rxd = 12'h000; mq_iq = 1'b0; mq_en = 1'b0;
      movf = 1'b0; msync = 1'b0; mo16 = 0; ms16 = 0; mo3 = 0; ms3 = 0;
    end else begin
      pop = mv && m_ready_i;
      push = 1'b0; slip = 1'b0; w = 24'h000000;
      if (!mq_en) begin
        have_a = 1'b0;
      end else if (!have_a) begin
        if (!mq_iq) begin a_val = mq_rxd; have_a = 1'b1; end
        else slip = 1'b1;
      end else if (mq_iq) begin
        push = 1'b1; w = {a_val, mq_rxd}; have_a = 1'b0;
      end else begin
        slip = 1'b1; a_val = mq_rxd;
      end
      full = (q.size() == 4);
      if (pop) begin void'(q.pop_front()); void'(qt.pop_front()); end
      drop = push && full && !pop;
      if (push && !drop) begin q.push_back(w); qt.push_back(t); end
      if (clr_i) begin
        movf = 1'b0; msync = 1'b0; mo16 = 0; ms16 = 0; mo3 = 0; ms3 = 0;
      end else begin
        if (drop) begin
          movf = 1'b1;
          if (mo16 < 65535) mo16++;
          if (mo3 < 7) mo3++;
        end
        if (slip) begin
          msync = 1'b1;
          if (ms16 < 65535) ms16++;
          if (ms3 < 7) ms3++;
        end
      end
      mq_rxd = rxd; mq_iq = rxiqsel; mq_en = en;
    end
    // a word becomes visible one edge after it was written
    mv = (q.size() > 0) && (qt[0] < t);
  end

  // compare DUT outputs with the model every cycle
  always @(negedge clk) begin
    chk("valid0", 32'(v0), 32'(mv));
    chk("valid1", 32'(v1), 32'(mv));
    chk("level0", 32'(l0), q.size());
    chk("level1", 32'(l1), q.size());
    if (mv) begin
      chk("data0", 32'(d0), 32'(q[0]));
      chk("data1", 32'(d1), 32'({q[0][11:0], q[0][23:12]}));
    end
    chk("ovf0", 32'(ovf0), 32'(movf));
    chk("ovf1", 32'(ovf1), 32'(movf));
    chk("ovfcnt0", 32'(oc0), mo16);
    chk("ovfcnt1", 32'(oc1), mo3);
    chk("syncerr0", 32'(se0), 32'(msync));
    chk("syncerr1", 32'(se1), 32'(msync));
    chk("synccnt0", 32'(sc0), ms16);
    chk("synccnt1", 32'(sc1), ms3);
  end

  task automatic step(input logic e, input logic iq, input logic [11:0] d, input logic r,
                      input logic c = 1'b0, input logic rs = 1'b0);
    en = e; rxiqsel = iq; rxd = d; m_ready_i = r; clr_i = c; rst = rs;
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] a, b;
    logic        iq_s, en_s, rdy_s, clr_s, rst_s;
    int          bias;

    @(negedge clk);
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 32'(v0), 32'h0);
    chk("rst_level", 32'(l0), 32'h0);
    chk("rst_data", 32'(d0), 32'h0);

    // basic pair and latency
    step(1'b1, 1'b0, 12'h123, 1'b1);
    step(1'b1, 1'b1, 12'h456, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("lat_valid_n1", 32'(v0), 32'h0);
    chk("lat_level_n1", 32'(l0), 32'h1);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("lat_valid_n2", 32'(v0), 32'h1);
    chk("pair_swap0", 32'(d0), 32'h123456);
    chk("pair_swap1", 32'(d1), 32'h456123);
    chk("pair_noerr", 32'(sc0), 32'h0);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("pair_drained", 32'(l0), 32'h0);

    // overflow: six words into a four-deep FIFO
    for (int i = 0; i < 6; i++) begin
      a = 12'h100 + 12'(i); b = 12'h200 + 12'(i);
      step(1'b1, 1'b0, a, 1'b0);
      step(1'b1, 1'b1, b, 1'b0);
    end
    step(1'b0, 1'b0, 12'h000, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b0);
    chk("ovf_level", 32'(l0), 32'h4);
    chk("ovf_cnt", 32'(oc0), 32'h2);
    chk("ovf_flag", 32'(ovf0), 32'h1);
    for (int i = 0; i < 4; i++) begin
      a = 12'h100 + 12'(i); b = 12'h200 + 12'(i);
      chk("ovf_drain_valid", 32'(v0), 32'h1);
      chk("ovf_drain_data", 32'(d0), 32'({a, b}));
      step(1'b0, 1'b0, 12'h000, 1'b1);
    end
    chk("ovf_drain_empty", 32'(l0), 32'h0);

    // full FIFO with simultaneous push and pop, then clear
    for (int i = 0; i < 4; i++) begin
      a = 12'h300 + 12'(i); b = 12'h400 + 12'(i);
      step(1'b1, 1'b0, a, 1'b0);
      step(1'b1, 1'b1, b, 1'b0);
    end
    step(1'b1, 1'b0, 12'h3AA, 1'b0);
    step(1'b1, 1'b1, 12'h4BB, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b0);
    chk("pp_level", 32'(l0), 32'h4);
    chk("pp_ovfcnt", 32'(oc0), 32'h2);
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    chk("clr_ovfcnt", 32'(oc0), 32'h0);
    chk("clr_ovf", 32'(ovf0), 32'h0);
    chk("clr_level", 32'(l0), 32'h4);
    chk("clr_head", 32'(d0), 32'h301401);
    for (int i = 1; i < 5; i++) begin
      a = (i == 4) ? 12'h3AA : 12'h300 + 12'(i);
      b = (i == 4) ? 12'h4BB : 12'h400 + 12'(i);
      chk("pp_drain_data", 32'(d0), 32'({a, b}));
      step(1'b0, 1'b0, 12'h000, 1'b1);
    end

    // pairing slips: 0,0,1,1,0,1
    step(1'b1, 1'b0, 12'h0A1, 1'b0);
    step(1'b1, 1'b0, 12'h0A2, 1'b0);
    step(1'b1, 1'b1, 12'h0B1, 1'b0);
    step(1'b1, 1'b1, 12'h0B2, 1'b0);
    step(1'b1, 1'b0, 12'h0A3, 1'b0);
    step(1'b1, 1'b1, 12'h0B3, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b0);
    chk("slip_cnt", 32'(sc0), 32'h2);
    chk("slip_flag", 32'(se0), 32'h1);
    chk("slip_level", 32'(l0), 32'h2);
    chk("slip_word1", 32'(d0), 32'h0A20B1);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("slip_word2", 32'(d0), 32'h0A30B3);
    step(1'b0, 1'b0, 12'h000, 1'b1);

    // reset with three words stored and an A held
    for (int i = 0; i < 3; i++) begin
      a = 12'h500 + 12'(i); b = 12'h600 + 12'(i);
      step(1'b1, 1'b0, a, 1'b0);
      step(1'b1, 1'b1, b, 1'b0);
    end
    step(1'b1, 1'b0, 12'h5AA, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b0);
    chk("prerst_level", 32'(l0), 32'h3);
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    chk("rst2_valid", 32'(v0), 32'h0);
    chk("rst2_level", 32'(l0), 32'h0);
    chk("rst2_sync", 32'(sc0), 32'h0);
    step(1'b1, 1'b0, 12'h7C1, 1'b1);
    step(1'b1, 1'b1, 12'h7C2, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("post_rst_word", 32'(d0), 32'h7C17C2);
    step(1'b0, 1'b0, 12'h000, 1'b1);

    // randomized traffic, checked by the model each cycle
    iq_s = 1'b1;
    bias = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) bias = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) != 0) iq_s = ~iq_s;
      en_s  = ($urandom_range(0, 15) != 0);
      rdy_s = (bias == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      clr_s = ($urandom_range(0, 99) == 0);
      rst_s = ($urandom_range(0, 499) == 0);
      step(en_s, iq_s, 12'($urandom), rdy_s, clr_s, rst_s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/myriadrf_rx_fifo_if.md
Name: myriadrf_rx_fifo_if

Overview:
Parametrised receive front-end for the MyriadRF transceiver's interleaved RX sample bus. It captures the multiplexed rxd/rxiqsel stream and pairs the two phases into one {A,B} word. It detects pairing slips, buffers words in a FIFO so the downstream consumer may apply backpressure, and counts dropped and misaligned samples. It sits between the transceiver pins (clk-domain registered) and the SoC streaming/DMA path.

Parameters:
DW, 12, sample width per phase; the output word is 2*DW.
DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 words (legal range 1..8).
SWAP, 0, 0: rxiqsel=0 sample (A) in m_data_o[2*DW-1:DW], rxiqsel=1 sample (B) in m_data_o[DW-1:0]; 1: halves exchanged.
CNT_W, 16, width of the error counters.

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  capture enable; 0 flushes pairing state, no pushes
clr_i  in  1  synchronous clear of counters and sticky flags, FIFO untouched
rxd  in  DW  transceiver sample bus
rxiqsel  in  1  phase select: 0 = A phase, 1 = B phase
m_data_o  out  2*DW  head-of-FIFO word
m_valid_o  out  1  FIFO non-empty
m_ready_i  in  1  consumer accepts word when m_valid_o & m_ready_i
level_o  out  DEPTH_LOG2+1  current FIFO occupancy
ovf_o  out  1  sticky: a word was dropped because the FIFO was full
ovf_cnt_o  out  CNT_W  dropped-word count, saturating
sync_err_o  out  1  sticky: pairing slip seen
sync_cnt_o  out  CNT_W  pairing-slip count, saturating

Behaviour:
- Reset (rst=1 at an edge): FIFO empty, m_valid_o=0, m_data_o=0, level_o=0, all flags/counters 0, input stage cleared, FSM=WAIT_A. Reset dominates clr_i, en and all traffic, including mid-pair and with FIFO full.
- Input stage: rxd, rxiqsel and en registered every edge (rxd_q, iq_q, en_q). The FSM acts only when en_q=1.
- Pairing FSM:
  - WAIT_A, iq_q=0: store A, go to HAVE_A.
  - WAIT_A, iq_q=1: slip; B discarded, sync_cnt++, sync_err set, stay in WAIT_A.
  - HAVE_A, iq_q=1: form word from held A and B (ordered per SWAP), push, go to WAIT_A.
  - HAVE_A, iq_q=0: slip; new A overwrites held A, sync_cnt++, sync_err set, stay in HAVE_A.
  - en_q=0: go to WAIT_A, held A discarded, no counting.
- Latency: a B sample on rxd at edge n is written to the FIFO at edge n+1. With the FIFO empty, m_valid_o=1 and m_data_o=word from edge n+2 onward (first-word-fall-through through an output register).
- FIFO:
  - Pop on m_valid_o & m_ready_i.
  - Push when full with no pop in the same cycle: word dropped, ovf set, ovf_cnt++. Stored contents are untouched.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Push and pop in the same cycle when empty: the word goes to the output register; level stays consistent.
  - Pointers wrap modulo 2^DEPTH_LOG2.
  - m_data_o is stable while m_valid_o=1 and m_ready_i=0.
- level_o counts words held, including the output register: 0..2^DEPTH_LOG2.
- Counters saturate at 2^CNT_W-1. clr_i zeros counters and flags. If clr_i coincides with an increment event, clr wins (result 0).
- Steady input rate: at most one word per two clocks. The consumer must sustain that average or overflow is counted.

Test Plan:
- Alternating rxiqsel 0,1 with rxd=0x123,0x456 (DW=12, SWAP=0), m_ready_i=1 -> m_data_o=0x123456, m_valid_o high 2 edges after the B sample; no errors.
- SWAP=1 with same stimulus -> m_data_o=0x456123.
- m_ready_i=0, DEPTH_LOG2=2, push 6 words -> level_o=4, ovf_cnt_o=2, ovf_o=1. Then drain -> the first 4 words come out in order, unchanged.
- rxiqsel pattern 0,0,1,1,0,1 -> sync_cnt_o=2. Words emitted: {A2,B1} and {A3,B3}, where A2 is the second A.
- Full FIFO with push and pop in the same cycle -> level_o stays 4, ovf_cnt_o unchanged. Assert clr_i -> counters and flags 0, FIFO contents intact.
- rst asserted with FIFO holding 3 words and the FSM in HAVE_A -> next edge: m_valid_o=0, level_o=0, counters 0. The next valid A/B pair emits correctly.
